hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
//  Detects RAW hazards, load-use hazards and taken branches, and freezes the pipe on multi-cycle data memory.
//  Drives stall/flush to every stage register and the PC; optional EX-stage forwarding selects.
//  Keeps saturating stall-cycle and flush-event counters.
// PARAMETERS
//  RA_W        5    register address width
//  CNT_W       32   width of stall_cnt / flush_cnt
//  MEM_TMO     255  wait cycles in MEM_WAIT before mem_timeout sets
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, asynchronous, active-high
//  id_rs1/id_rs2  in   RA_W   ID-stage source regs
//  id_rs1_used/id_rs2_used in 1  source is read by the ID instruction
//  ex_rs1/ex_rs2  in   RA_W   EX-stage source regs (forwarding only)
//  ex_wR, mem_wR, wb_wR  in RA_W  dest reg per stage
//  ex_rf_we, mem_rf_we, wb_rf_we in 2  00 none, 01 ALU, 10 load, 11 link(pc+4)
//  ex_branch_taken in  1      branch/jump resolved taken in EX
//  mem_req        in   1      MEM-stage instruction accesses data memory
//  mem_ready      in   1      data memory completes this cycle
//  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out 1  hold register
//  if_id_flush, id_ex_flush  out 1  load bubble (all fields 0) next edge
//  fwd1_sel, fwd2_sel out 2  EX operand: 00 RF/ID_EX, 01 EX/MEM result, 10 MEM/WB wD (FWD_EN only)
//  stall_cnt, flush_cnt out CNT_W  saturating counters;  mem_timeout out 1 sticky
// BEHAVIOUR
//  - Reset: state RUN, all counters 0, mem_timeout 0; control outputs combinational, all 0 in reset.
//  - Controls are combinational, same cycle as inputs; counters/state update on next posedge.
//  - Reg 0 never produces a hazard or forward. A writer matches only if rf_we != 00.
//  - FSM RUN: mem_req & !mem_ready -> MEM_WAIT (freeze asserted this cycle already).
//    MEM_WAIT: freeze; mem_ready -> RUN, freeze deasserted in that cycle, normal evaluation.
//    Wait counter clears on entry; reaching MEM_TMO sets mem_timeout (held until rst); stays in MEM_WAIT.
//  - freeze: all five *_stall = 1, both flushes = 0, fwd sels hold evaluation from inputs.
//  - Priority: freeze > branch flush > data-hazard stall.
//  - Branch (not frozen): if_id_flush = id_ex_flush = 1, no stalls; masks any hazard in same cycle.
//  - Load-use (ex_rf_we==10, ex_wR matches a used ID src): pc_stall, if_id_stall, id_ex_flush; 1 cycle.
//  - RF has write-through bypass: WB writer never causes an ID hazard.
//  - stall_cnt +1 per cycle with pc_stall; flush_cnt +1 per branch flush; both stop at all-ones.
//  - rst mid-MEM_WAIT: immediately RUN, outputs 0, counters 0.
// CONFIGURATION
//  HAZARD_FWD_EN defined: fwd sels active; MEM match (rf_we 01/11) beats WB match (any);
//    only load-use stalls. A load in MEM matching EX src cannot occur (load-use bubble).
//  Undefined: fwd1_sel = fwd2_sel = 00; ID stalls (pc, if_id stall + id_ex_flush)
//    while any used src matches EX or MEM writer; load-use rule subsumed.
// STRUCTURE
//  Shared package pipe_pkg: RF_WE_* encodings, FWD_* select codes, hazard state enum (RUN, MEM_WAIT).
//  Sub-module fwd_unit: combinational forwarding-select logic, instantiated under HAZARD_FWD_EN.
// TESTING
//  1 Load-use: ex_rf_we=10, ex_wR=5, id_rs1=5 used -> 1 cycle pc_stall+id_ex_flush; stall_cnt=1.
//  2 FWD_EN: mem_rf_we=01 mem_wR=7, wb_rf_we=01 wb_wR=7, ex_rs2=7 -> fwd2_sel=01; no stall.
//    FWD off: id_rs2=7 used, mem_wR=7 -> stall until instr leaves MEM (2 cycles if in EX).
//  3 Branch + load-use same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1.
//  4 mem_req, mem_ready low 4 cycles -> all stalls high 4 cycles, drop on ready cycle; stall_cnt=4.
//  5 MEM_TMO=3, mem_ready never -> mem_timeout=1 after 3 wait cycles; rst clears to RUN.
//  6 Writes to reg 0 (ex_wR=0, load) with id_rs1=0 -> no stall, fwd sel 00.

Source files
------------

// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared encodings for the 5-stage core pipeline sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [1:0] RF_WE_NONE = 2'b00;
  localparam logic [1:0] RF_WE_ALU  = 2'b01;
  localparam logic [1:0] RF_WE_LOAD = 2'b10;
  localparam logic [1:0] RF_WE_LINK = 2'b11;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_t;

  function automatic logic we_active(input logic [1:0] we);
    return we != RF_WE_NONE;
  endfunction

  // Only ALU and link results exist in EX/MEM; load data arrives later.
  function automatic logic we_mem_fwdable(input logic [1:0] we);
    return (we == RF_WE_ALU) || (we == RF_WE_LINK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_unit.sv
// ============================================================================
// fwd_unit : EX-stage operand forwarding select (MEM result beats WB data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_unit
  import pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] i_ex_rs1,
  input  logic [RA_W-1:0] i_ex_rs2,
  input  logic [RA_W-1:0] i_mem_wR,
  input  logic [1:0]      i_mem_rf_we,
  input  logic [RA_W-1:0] i_wb_wR,
  input  logic [1:0]      i_wb_rf_we,
  output logic [1:0]      o_fwd1_sel,
  output logic [1:0]      o_fwd2_sel
);

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (we_mem_fwdable(i_mem_rf_we) && (rs == i_mem_wR))
        sel = FWD_EXMEM;
      else if (we_active(i_wb_rf_we) && (rs == i_wb_wR))
        sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin
    o_fwd1_sel = fwd_sel(i_ex_rs1);
    o_fwd2_sel = fwd_sel(i_ex_rs2);
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : stall/flush sequencer with memory freeze and event counters.
//               Define HAZARD_FWD_EN to enable EX-stage forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int CNT_W   = 32,
  parameter int MEM_TMO = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  i_id_rs1,
  input  logic [RA_W-1:0]  i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [RA_W-1:0]  i_ex_rs1,
  input  logic [RA_W-1:0]  i_ex_rs2,
  input  logic [RA_W-1:0]  i_ex_wR,
  input  logic [RA_W-1:0]  i_mem_wR,
  input  logic [RA_W-1:0]  i_wb_wR,
  input  logic [1:0]       i_ex_rf_we,
  input  logic [1:0]       i_mem_rf_we,
  input  logic [1:0]       i_wb_rf_we,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_stall,
  output logic             o_if_id_stall,
  output logic             o_id_ex_stall,
  output logic             o_ex_mem_stall,
  output logic             o_mem_wb_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic [1:0]       o_fwd1_sel,
  output logic [1:0]       o_fwd2_sel,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic             o_mem_timeout
);

  localparam int TW = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO + 1);
  localparam logic [TW-1:0] c_tmo = TW'(MEM_TMO);

  hz_state_t        r_state;
  logic [TW-1:0]    r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_freeze, w_hazard;
  logic w_id1_ex, w_id2_ex;
  logic [1:0] w_fwd1_sel, w_fwd2_sel;

  always_comb begin
    w_id1_ex = i_id_rs1_used && (i_id_rs1 != '0) && we_active(i_ex_rf_we) && (i_id_rs1 == i_ex_wR);
    w_id2_ex = i_id_rs2_used && (i_id_rs2 != '0) && we_active(i_ex_rf_we) && (i_id_rs2 == i_ex_wR);
  end

  assign w_freeze = (r_state == ST_RUN) ? (i_mem_req && !i_mem_ready) : !i_mem_ready;

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign w_hazard = (i_ex_rf_we == RF_WE_LOAD) && (w_id1_ex || w_id2_ex);

  fwd_unit #(.RA_W(RA_W)) u_fwd (
    .i_ex_rs1    (i_ex_rs1),
    .i_ex_rs2    (i_ex_rs2),
    .i_mem_wR    (i_mem_wR),
    .i_mem_rf_we (i_mem_rf_we),
    .i_wb_wR     (i_wb_wR),
    .i_wb_rf_we  (i_wb_rf_we),
    .o_fwd1_sel  (w_fwd1_sel),
    .o_fwd2_sel  (w_fwd2_sel)
  );
`else
  logic w_id1_mem, w_id2_mem;
  logic w_unused_fwd_inputs;

  always_comb begin
    w_id1_mem = i_id_rs1_used && (i_id_rs1 != '0) && we_active(i_mem_rf_we) && (i_id_rs1 == i_mem_wR);
    w_id2_mem = i_id_rs2_used && (i_id_rs2 != '0) && we_active(i_mem_rf_we) && (i_id_rs2 == i_mem_wR);
  end

  // The RF write-through bypass makes WB writers invisible to ID.
  assign w_hazard   = w_id1_ex || w_id2_ex || w_id1_mem || w_id2_mem;
  assign w_fwd1_sel = FWD_RF;
  assign w_fwd2_sel = FWD_RF;
  assign w_unused_fwd_inputs = ^{i_ex_rs1, i_ex_rs2, i_wb_wR, i_wb_rf_we};
`endif

  always_comb begin
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_ex_mem_stall = 1'b0;
    o_mem_wb_stall = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_fwd1_sel     = FWD_RF;
    o_fwd2_sel     = FWD_RF;
    if (!rst) begin
      o_fwd1_sel = w_fwd1_sel;
      o_fwd2_sel = w_fwd2_sel;
      if (w_freeze) begin
        o_pc_stall     = 1'b1;
        o_if_id_stall  = 1'b1;
        o_id_ex_stall  = 1'b1;
        o_ex_mem_stall = 1'b1;
        o_mem_wb_stall = 1'b1;
      end else if (i_ex_branch_taken) begin
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (w_hazard) begin
        o_pc_stall    = 1'b1;
        o_if_id_stall = 1'b1;
        o_id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_mem_req && !i_mem_ready) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (i_mem_ready) begin
            r_state <= ST_RUN;
          end else if (r_wait_cnt != c_tmo) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (TW'(r_wait_cnt + 1'b1) == c_tmo)
              r_mem_timeout <= 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (o_pc_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (o_if_id_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
  assign o_mem_timeout = r_mem_timeout;

endmodule

`default_nettype wire
